// File: rtl/cardinality_check_initiator_if.sv
// rtl/cardinality_check_initiator_if.sv - go/done requester bundle between a stage controller and its cardinality checkers
//
// Purpose: groups the start/busy control, the per-checker go/done/cardinality
// lines and the valid/ready result port of the cardinality check initiator.
//
// Signals (NUM_CHECKS wide unless noted):
//   start              1   begin a check sequence (sampled only when idle)
//   busy               1   initiator is not idle
//   check_go               one-hot single-cycle go pulse to checker i
//   check_done             done from checker i
//   check_cardinality      final cardinality from checker i, valid with its done
//   result_valid       1   result available
//   result_ready       1   consumer accepts the result
//   result_parity          latched cardinality per check
//   result_odd         1   OR-reduction of result_parity
//   result_error_mask      bit i set if check i timed out
//
// Modports:
//   master - the initiator itself
//   slave  - the environment (stage controller, checkers, result consumer)

interface cardinality_check_initiator_if #(
  parameter int NUM_CHECKS = 2
);
  logic                  start;
  logic                  busy;
  logic [NUM_CHECKS-1:0] check_go;
  logic [NUM_CHECKS-1:0] check_done;
  logic [NUM_CHECKS-1:0] check_cardinality;
  logic                  result_valid;
  logic                  result_ready;
  logic [NUM_CHECKS-1:0] result_parity;
  logic                  result_odd;
  logic [NUM_CHECKS-1:0] result_error_mask;

  modport master (
    input  start,
    input  check_done,
    input  check_cardinality,
    input  result_ready,
    output busy,
    output check_go,
    output result_valid,
    output result_parity,
    output result_odd,
    output result_error_mask
  );

  modport slave (
    output start,
    output check_done,
    output check_cardinality,
    output result_ready,
    input  busy,
    input  check_go,
    input  result_valid,
    input  result_parity,
    input  result_odd,
    input  result_error_mask
  );
endinterface

// File: rtl/cardinality_check_initiator.sv
// rtl/cardinality_check_initiator.sv - sequential go/done requester for the per-boundary cardinality checkers
//
// Purpose: on a start pulse, runs checkers 0..NUM_CHECKS-1 one after another
// (index 0 = X boundary, index 1 = Z boundary). Each checker gets a single
// cycle go, then the initiator waits for that checker's done (bounded by
// TIMEOUT_CYCLES) and latches its cardinality bit. The collected parities and
// the timeout mask are then offered on a valid/ready result port.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - cardinality_check_initiator_if.master (start/busy, go/done/
//            cardinality per checker, result valid/ready/parity/odd/mask)
//
// Configuration macro:
//   CARDINALITY_CHECK_RETRY_EN - when defined, the first timeout on a check
//   re-issues go for the same index once; only a second timeout marks it.

module cardinality_check_initiator #(
  parameter int NUM_CHECKS     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  cardinality_check_initiator_if.master bus
);

  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_CHECKS - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CHECKS-1:0]  ONE_HOT0   = NUM_CHECKS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        index_q;
  logic [TIMER_WIDTH-1:0]  timer_q;
  logic [NUM_CHECKS-1:0]   parity_q;
  logic [NUM_CHECKS-1:0]   mask_q;
  logic [NUM_CHECKS-1:0]   go_q;
  logic                    busy_q;
  logic                    valid_q;
  logic                    odd_q;
`ifdef CARDINALITY_CHECK_RETRY_EN
  logic                    retried_q;
`endif

  // Only the done/cardinality of the checker currently being serviced matter;
  // done bits from other indices are never looked at.
  logic                  done_w;
  logic                  card_w;
  logic                  timeout_w;
  logic                  last_w;
  logic [NUM_CHECKS-1:0] index_onehot_w;
  logic [NUM_CHECKS-1:0] parity_d;
  logic [NUM_CHECKS-1:0] mask_d;

  assign done_w         = bus.check_done[index_q];
  assign card_w         = bus.check_cardinality[index_q];
  // done takes priority over an expiring timer in the same cycle
  assign timeout_w      = !done_w && (timer_q == TIMER_LAST);
  assign last_w         = (index_q == LAST_IDX);
  assign index_onehot_w = ONE_HOT0 << index_q;

  // Parity/mask as they become once the current check resolves: the done
  // path takes the checker's bit, a timeout forces parity 0 and sets the mask.
  always_comb begin
    parity_d = parity_q;
    mask_d   = mask_q;
    if (done_w) begin
      parity_d[index_q] = card_w;
    end else begin
      parity_d[index_q] = 1'b0;
      mask_d[index_q]   = 1'b1;
    end
  end

  // go, busy, valid and odd are registered alongside the state so the outputs
  // change only on clock edges; go is pre-loaded on entry to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      timer_q   <= '0;
      parity_q  <= '0;
      mask_q    <= '0;
      go_q      <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      odd_q     <= 1'b0;
`ifdef CARDINALITY_CHECK_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= ISSUE;
            index_q   <= '0;
            parity_q  <= '0;
            mask_q    <= '0;
            odd_q     <= 1'b0;
            go_q      <= ONE_HOT0;
            busy_q    <= 1'b1;
`ifdef CARDINALITY_CHECK_RETRY_EN
            retried_q <= 1'b0;
`endif
          end
        end

        ISSUE: begin
          // done seen here belongs to no go of ours yet and is dropped
          go_q    <= '0;
          timer_q <= '0;
          state_q <= WAIT;
        end

        WAIT: begin
`ifdef CARDINALITY_CHECK_RETRY_EN
          if (timeout_w && !retried_q) begin
            // first timeout: one more go for the same checker, fresh timer
            retried_q <= 1'b1;
            go_q      <= index_onehot_w;
            state_q   <= ISSUE;
          end else
`endif
          if (done_w || timeout_w) begin
            parity_q <= parity_d;
            mask_q   <= mask_d;
`ifdef CARDINALITY_CHECK_RETRY_EN
            retried_q <= 1'b0;
`endif
            if (last_w) begin
              state_q <= REPORT;
              valid_q <= 1'b1;
              odd_q   <= |parity_d;
            end else begin
              index_q <= index_q + 1'b1;
              go_q    <= index_onehot_w << 1;
              state_q <= ISSUE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        REPORT: begin
          // result registers are untouched here, so they hold while stalled
          if (bus.result_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          go_q    <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy              = busy_q;
  assign bus.check_go          = go_q;
  assign bus.result_valid      = valid_q;
  assign bus.result_parity     = parity_q;
  assign bus.result_odd        = odd_q;
  assign bus.result_error_mask = mask_q;

endmodule

// File: tb/tb_cardinality_check_initiator.sv
// tb/tb_cardinality_check_initiator.sv - directed self-checking bench for cardinality_check_initiator

module tb_cardinality_check_initiator;

  localparam int NC = 2;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  cardinality_check_initiator_if #(.NUM_CHECKS(NC)) bus ();

  cardinality_check_initiator #(
    .NUM_CHECKS     (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // start at edge t, responder answers 1 cycle after each go; ends in REPORT (t+5)
  task automatic run_normal(input string tag, input logic [1:0] card);
    bus.start = 1'b1;
    cyc();                                   // t+1: ISSUE 0
    bus.start = 1'b0;
    chk({tag, "_go0"},  bus.check_go, 2'b01);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    cyc();                                   // t+2: WAIT 0
    chk({tag, "_go_off0"}, bus.check_go, 2'b00);
    bus.check_done = 2'b01;
    bus.check_cardinality = {1'b0, card[0]};
    cyc();                                   // t+3: ISSUE 1
    bus.check_done = 2'b00;
    bus.check_cardinality = 2'b00;
    chk({tag, "_go1"}, bus.check_go, 2'b10);
    chk({tag, "_nv3"}, bus.result_valid, 1'b0);
    cyc();                                   // t+4: WAIT 1
    chk({tag, "_go_off1"}, bus.check_go, 2'b00);
    chk({tag, "_nv4"}, bus.result_valid, 1'b0);
    bus.check_done = 2'b10;
    bus.check_cardinality = {card[1], 1'b0};
    cyc();                                   // t+5: REPORT
    bus.check_done = 2'b00;
    bus.check_cardinality = 2'b00;
    chk({tag, "_valid"},  bus.result_valid, 1'b1);
    chk({tag, "_parity"}, bus.result_parity, card);
    chk({tag, "_odd"},    bus.result_odd, |card);
    chk({tag, "_mask"},   bus.result_error_mask, 2'b00);
  endtask

  task automatic accept(input string tag);
    bus.result_ready = 1'b1;
    cyc();
    bus.result_ready = 1'b0;
    chk({tag, "_acc_valid"}, bus.result_valid, 1'b0);
    chk({tag, "_acc_busy"},  bus.busy, 1'b0);
  endtask

  initial begin
    bus.start             = 1'b0;
    bus.check_done        = 2'b00;
    bus.check_cardinality = 2'b00;
    bus.result_ready      = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_go",    bus.check_go, 2'b00);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_par",   bus.result_parity, 2'b00);
    chk("rst_odd",   bus.result_odd, 1'b0);
    chk("rst_mask",  bus.result_error_mask, 2'b00);
    reset = 1'b0;
    cyc();
    chk("idle_busy", bus.busy, 1'b0);

    // 1: X=1, Z=0
    run_normal("s1", 2'b01);

    // 2: stall in REPORT with a start pulse that must be ignored
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      cyc();
      chk("s2_valid", bus.result_valid, 1'b1);
      chk("s2_par",   bus.result_parity, 2'b01);
      chk("s2_go",    bus.check_go, 2'b00);
    end
    bus.start = 1'b0;
    accept("s2");
    cyc();
    chk("s2_no_restart_go",   bus.check_go, 2'b00);
    chk("s2_no_restart_busy", bus.busy, 1'b0);

`ifndef CARDINALITY_CHECK_RETRY_EN
    // 3: checker 1 never answers
    bus.start = 1'b1;
    cyc();                                   // t+1
    bus.start = 1'b0;
    chk("s3_go0", bus.check_go, 2'b01);
    cyc();                                   // t+2
    bus.check_done = 2'b01;
    bus.check_cardinality = 2'b00;
    cyc();                                   // t+3
    bus.check_done = 2'b00;
    chk("s3_go1", bus.check_go, 2'b10);
    cyc();                                   // t+4
    for (int i = 0; i < TO; i++) begin       // WAIT t+4..t+19
      chk("s3_wait_valid", bus.result_valid, 1'b0);
      chk("s3_wait_go",    bus.check_go, 2'b00);
      cyc();
    end
    chk("s3_valid", bus.result_valid, 1'b1);    // t+20
    chk("s3_mask",  bus.result_error_mask, 2'b10);
    chk("s3_par",   bus.result_parity, 2'b00);
    chk("s3_odd",   bus.result_odd, 1'b0);
    accept("s3");
`endif

    // done on the final timer cycle of check 0 beats the timeout
    bus.start = 1'b1;
    cyc();                                   // t+1 ISSUE
    bus.start = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin   // WAIT t+2..t+16, silent
      cyc();
      chk("edge_wait_go", bus.check_go, 2'b00);
    end
    cyc();                                   // t+17: timer == TO-1
    bus.check_done = 2'b01;
    bus.check_cardinality = 2'b01;
    cyc();                                   // t+18 ISSUE 1
    bus.check_done = 2'b00;
    bus.check_cardinality = 2'b00;
    chk("edge_go1", bus.check_go, 2'b10);
    cyc();                                   // t+19 WAIT 1
    bus.check_done = 2'b10;
    cyc();                                   // t+20 REPORT
    bus.check_done = 2'b00;
    chk("edge_valid", bus.result_valid, 1'b1);
    chk("edge_mask",  bus.result_error_mask, 2'b00);
    chk("edge_par",   bus.result_parity, 2'b01);
    accept("edge");

    // 4: reset during WAIT of check 0, then a clean run
    bus.start = 1'b1;
    cyc();                                   // t+1
    bus.start = 1'b0;
    cyc();                                   // t+2 WAIT
    reset = 1'b1;
    cyc();                                   // t+3
    reset = 1'b0;
    chk("s4_busy",  bus.busy, 1'b0);
    chk("s4_go",    bus.check_go, 2'b00);
    chk("s4_valid", bus.result_valid, 1'b0);
    run_normal("s4", 2'b11);
    accept("s4");

    // 5: spurious done from checker 1 while waiting on checker 0
    bus.start = 1'b1;
    cyc();                                   // t+1
    bus.start = 1'b0;
    cyc();                                   // t+2 WAIT 0
    bus.check_done = 2'b10;
    bus.check_cardinality = 2'b10;
    cyc();                                   // t+3 still WAIT 0
    chk("s5_still_wait", bus.check_go, 2'b00);
    bus.check_done = 2'b01;
    bus.check_cardinality = 2'b00;
    cyc();                                   // t+4 ISSUE 1
    bus.check_done = 2'b00;
    chk("s5_go1", bus.check_go, 2'b10);
    cyc();                                   // t+5 WAIT 1
    bus.check_done = 2'b10;
    bus.check_cardinality = 2'b00;
    cyc();                                   // t+6 REPORT
    bus.check_done = 2'b00;
    chk("s5_valid", bus.result_valid, 1'b1);
    chk("s5_par",   bus.result_parity, 2'b00);
    chk("s5_odd",   bus.result_odd, 1'b0);
    accept("s5");

`ifdef CARDINALITY_CHECK_RETRY_EN
    // 6: checker 0 answers only its second go
    begin
      int go0_count = 0;
      bus.start = 1'b1;
      cyc();                                 // t+1
      bus.start = 1'b0;
      for (int c = 1; c <= 18; c++) begin    // t+1..t+18
        if (bus.check_go[0]) go0_count++;
        chk("s6_go0_timing", bus.check_go, (c == 1 || c == 18) ? 2'b01 : 2'b00);
        if (c < 18) cyc();
      end
      chk("s6_go0_count", go0_count, 2);
      cyc();                                 // t+19 WAIT 0 (retry)
      bus.check_done = 2'b01;
      bus.check_cardinality = 2'b01;
      cyc();                                 // t+20 ISSUE 1
      bus.check_done = 2'b00;
      bus.check_cardinality = 2'b00;
      chk("s6_go1", bus.check_go, 2'b10);
      cyc();                                 // t+21 WAIT 1
      bus.check_done = 2'b10;
      cyc();                                 // t+22 REPORT
      bus.check_done = 2'b00;
      chk("s6_valid", bus.result_valid, 1'b1);
      chk("s6_mask",  bus.result_error_mask, 2'b00);
      chk("s6_par",   bus.result_parity, 2'b01);
      accept("s6");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
